// File: rtl/vend_pkg.sv
// Shared types and default sizing for the vending dispense path.
package vend_pkg;

    localparam int unsigned NUM_SLOTS_DEF    = 16;
    localparam int unsigned IDX_W_DEF        = 4;
    localparam int unsigned CNT_W_DEF        = 4;
    localparam int unsigned INIT_COUNT_DEF   = 5;
    localparam int unsigned MOTOR_CYCLES_DEF = 8;
    localparam int unsigned DROP_TIMEOUT_DEF = 40;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MOTOR,
        WAIT_DROP,
        DONE
    } disp_state_e;

    // Front-end selection FSM codes, shared so both sides agree on encoding.
    typedef enum logic [1:0] {
        SELECT   = 2'b00,
        DISPENSE = 2'b01,
        CANCEL   = 2'b11
    } fe_state_e;

endpackage

// File: rtl/inventory_store.sv
// Per-slot inventory counts: reset load, saturating restock, guarded decrement.
module inventory_store
    import vend_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = NUM_SLOTS_DEF,
    parameter int unsigned IDX_W      = IDX_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned INIT_COUNT = INIT_COUNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restock_en,
    input  logic [IDX_W-1:0] restock_idx,
    input  logic [CNT_W-1:0] restock_cnt,
    input  logic             dec_en,
    input  logic [IDX_W-1:0] dec_idx,
    input  logic [IDX_W-1:0] query_idx,
    output logic [CNT_W-1:0] query_cnt,
    input  logic [IDX_W-1:0] check_idx,
    output logic [CNT_W-1:0] check_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q [NUM_SLOTS];
    logic [CNT_W-1:0] count_d [NUM_SLOTS];
    logic [CNT_W:0]   sum;

    // Indices beyond NUM_SLOTS read as empty and are never written.
    assign query_cnt = (32'(query_idx) < NUM_SLOTS) ? count_q[query_idx] : '0;
    assign check_cnt = (32'(check_idx) < NUM_SLOTS) ? count_q[check_idx] : '0;

    always_comb begin
        count_d = count_q;
        sum     = '0;
        if (restock_en && (32'(restock_idx) < NUM_SLOTS)) begin
            sum = {1'b0, count_q[restock_idx]} + {1'b0, restock_cnt};
            count_d[restock_idx] = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
        end
        if (dec_en && (32'(dec_idx) < NUM_SLOTS) && (count_q[dec_idx] != '0)) begin
            count_d[dec_idx] = count_q[dec_idx] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                count_q[i] <= CNT_W'(INIT_COUNT);
            end
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dispense_controller.sv
// Sequences the shared dispenser motor for one req/done transaction at a time.
module dispense_controller
    import vend_pkg::*;
#(
    parameter int unsigned NUM_SLOTS    = NUM_SLOTS_DEF,
    parameter int unsigned IDX_W        = IDX_W_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned INIT_COUNT   = INIT_COUNT_DEF,
    parameter int unsigned MOTOR_CYCLES = MOTOR_CYCLES_DEF,
    parameter int unsigned DROP_TIMEOUT = DROP_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dispenseReq,
    input  logic [IDX_W-1:0] dispenseIndex,
    input  logic             dispenseCancel,
    input  logic             dropSensor,
    input  logic             restockEn,
    input  logic [IDX_W-1:0] restockIndex,
    input  logic [CNT_W-1:0] restockCount,
    input  logic             faultClear,
    input  logic [IDX_W-1:0] queryIndex,
    output logic             stockAvail,
    output logic             motorEn,
    output logic [IDX_W-1:0] motorSel,
    output logic             dispenseDone,
    output logic             dispenseOk,
    output logic             jamFault
);

    localparam int unsigned TMR_MAX = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;

    disp_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             motor_en_q, motor_en_d;
    logic [IDX_W-1:0] motor_sel_q, motor_sel_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic             jam_q, jam_d;
    logic             drop_pend_q, drop_pend_d;

    logic [CNT_W-1:0] query_cnt, check_cnt;
    logic             dec_en, restock_apply;
    logic             accept, check_fail, motor_last, drop_seen, drop_expired;

    inventory_store #(
        .NUM_SLOTS  (NUM_SLOTS),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W),
        .INIT_COUNT (INIT_COUNT)
    ) u_inventory (
        .clk         (clk),
        .rst         (rst),
        .restock_en  (restock_apply),
        .restock_idx (restockIndex),
        .restock_cnt (restockCount),
        .dec_en      (dec_en),
        .dec_idx     (idx_q),
        .query_idx   (queryIndex),
        .query_cnt   (query_cnt),
        .check_idx   (idx_q),
        .check_cnt   (check_cnt)
    );

    // Restock has priority over a same-cycle request; the held req is taken next cycle.
    assign accept       = dispenseReq && !done_q && !restockEn;
    assign check_fail   = dispenseCancel || (check_cnt == '0) || jam_q;
    assign motor_last   = (timer_q == TMR_W'(MOTOR_CYCLES - 1));
    assign drop_seen    = drop_pend_q || dropSensor;
    assign drop_expired = (timer_q == TMR_W'(DROP_TIMEOUT - 1));

    assign stockAvail   = (query_cnt != '0) && !jam_q;
    assign motorEn      = motor_en_q;
    assign motorSel     = motor_sel_q;
    assign dispenseDone = done_q;
    assign dispenseOk   = ok_q;
    assign jamFault     = jam_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            timer_q     <= '0;
            motor_en_q  <= 1'b0;
            motor_sel_q <= '0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            jam_q       <= 1'b0;
            drop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            motor_en_q  <= motor_en_d;
            motor_sel_q <= motor_sel_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            jam_q       <= jam_d;
            drop_pend_q <= drop_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = CHECK;
            CHECK:     state_d = check_fail ? DONE : MOTOR;
            MOTOR:     if (motor_last) state_d = WAIT_DROP;
            WAIT_DROP: if (drop_seen || drop_expired) state_d = DONE;
            DONE:      if (!dispenseReq) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d         = idx_q;
        timer_d       = timer_q;
        motor_en_d    = motor_en_q;
        motor_sel_d   = motor_sel_q;
        done_d        = done_q;
        ok_d          = ok_q;
        jam_d         = jam_q;
        drop_pend_d   = drop_pend_q;
        dec_en        = 1'b0;
        restock_apply = 1'b0;
        case (state_q)
            IDLE: begin
                restock_apply = restockEn;
                if (faultClear) jam_d = 1'b0;
                if (accept) begin
                    idx_d       = dispenseIndex;
                    drop_pend_d = 1'b0;
                end
            end
            CHECK: begin
                if (check_fail) begin
                    done_d = 1'b1;
                    ok_d   = 1'b0;
                end else begin
                    dec_en      = 1'b1;
                    motor_en_d  = 1'b1;
                    motor_sel_d = idx_q;
                    timer_d     = '0;
                end
            end
            MOTOR: begin
                if (dropSensor) drop_pend_d = 1'b1;
                if (motor_last) begin
                    motor_en_d = 1'b0;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            WAIT_DROP: begin
                if (drop_seen) begin
                    done_d = 1'b1;
                    ok_d   = 1'b1;
                end else if (drop_expired) begin
                    jam_d  = 1'b1;
                    done_d = 1'b1;
                    ok_d   = 1'b0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DONE: begin
                if (!dispenseReq) begin
                    done_d = 1'b0;
                    ok_d   = 1'b0;
                end
            end
            default: motor_en_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_dispense_controller.sv
// Directed bench for dispense_controller with hand-computed latencies and results.
module tb_dispense_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       dispenseReq;
    logic [3:0] dispenseIndex;
    logic       dispenseCancel;
    logic       dropSensor;
    logic       restockEn;
    logic [3:0] restockIndex;
    logic [3:0] restockCount;
    logic       faultClear;
    logic [3:0] queryIndex;
    logic       stockAvail;
    logic       motorEn;
    logic [3:0] motorSel;
    logic       dispenseDone;
    logic       dispenseOk;
    logic       jamFault;

    int n_checks = 0;
    int n_errors = 0;

    dispense_controller dut (
        .clk            (clk),
        .rst            (rst),
        .dispenseReq    (dispenseReq),
        .dispenseIndex  (dispenseIndex),
        .dispenseCancel (dispenseCancel),
        .dropSensor     (dropSensor),
        .restockEn      (restockEn),
        .restockIndex   (restockIndex),
        .restockCount   (restockCount),
        .faultClear     (faultClear),
        .queryIndex     (queryIndex),
        .stockAvail     (stockAvail),
        .motorEn        (motorEn),
        .motorSel       (motorSel),
        .dispenseDone   (dispenseDone),
        .dispenseOk     (dispenseOk),
        .jamFault       (jamFault)
    );

    always #50 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_avail(input logic [3:0] idx, input logic exp, input string tag);
        queryIndex = idx;
        #1;
        check_val(tag, 32'(stockAvail), 32'(exp));
    endtask

    // Cycle 0 is the IDLE cycle in which req is first presented.
    task automatic do_disp(input logic [3:0] idx, input int drop_cyc, input int cancel_from,
                           input int cancel_to, input logic restock_same,
                           output logic ok, output int lat, output int mcnt, output logic sel_bad);
        int   cyc;
        logic got_done;
        cyc = 0; got_done = 1'b0; ok = 1'b0; lat = -1; mcnt = 0; sel_bad = 1'b0;
        dispenseReq    = 1'b1;
        dispenseIndex  = idx;
        dropSensor     = (drop_cyc == 0);
        dispenseCancel = (cancel_from <= 0) && (cancel_to >= 0);
        restockEn      = restock_same;
        restockIndex   = idx;
        restockCount   = 4'd1;
        while (!got_done && cyc < 200) begin
            tick();
            cyc++;
            restockEn = 1'b0;
            if (cyc >= (restock_same ? 2 : 1)) dispenseIndex = ~idx;
            if (motorEn) begin
                mcnt++;
                if (motorSel !== idx) sel_bad = 1'b1;
            end
            if (dispenseDone) begin
                got_done = 1'b1;
                ok       = dispenseOk;
                lat      = cyc;
            end
            dropSensor     = (cyc == drop_cyc);
            dispenseCancel = (cyc >= cancel_from) && (cyc <= cancel_to);
        end
        if (!got_done) check_val("disp_timeout", 32'(got_done), 32'd1);
        dispenseReq    = 1'b0;
        dropSensor     = 1'b0;
        dispenseCancel = 1'b0;
        tick();
        check_val("done_release", 32'(dispenseDone), 32'd0);
    endtask

    initial begin
        logic        ok, sel_bad;
        int          lat, mc, n_ok;
        logic [15:0] avail_mask;

        rst = 1'b1; dispenseReq = 0; dispenseIndex = 0; dispenseCancel = 0; dropSensor = 0;
        restockEn = 0; restockIndex = 0; restockCount = 0; faultClear = 0; queryIndex = 0;
        repeat (3) tick();
        check_val("rst_motorEn", 32'(motorEn), 32'd0);
        check_val("rst_motorSel", 32'(motorSel), 32'd0);
        check_val("rst_done", 32'(dispenseDone), 32'd0);
        check_val("rst_ok", 32'(dispenseOk), 32'd0);
        check_val("rst_jam", 32'(jamFault), 32'd0);
        rst = 1'b0;
        tick();
        chk_avail(4'd0, 1'b1, "rst_avail0");

        // Single dispense from slot 3, drop two cycles after motor off.
        do_disp(4'd3, 12, -1, -1, 1'b0, ok, lat, mc, sel_bad);
        check_val("s3_ok", 32'(ok), 32'd1);
        check_val("s3_lat", 32'(lat), 32'd13);
        check_val("s3_motor_cycles", 32'(mc), 32'd8);
        check_val("s3_sel", 32'(sel_bad), 32'd0);
        chk_avail(4'd3, 1'b1, "s3_avail");

        // Slot 3 should hold exactly four more items.
        n_ok = 0;
        for (int i = 0; i < 4; i++) begin
            do_disp(4'd3, 10, -1, -1, 1'b0, ok, lat, mc, sel_bad);
            if (ok && lat == 11) n_ok++;
        end
        check_val("s3_drain_ok", 32'(n_ok), 32'd4);
        do_disp(4'd3, 10, -1, -1, 1'b0, ok, lat, mc, sel_bad);
        check_val("s3_empty_ok", 32'(ok), 32'd0);
        chk_avail(4'd3, 1'b0, "s3_empty_avail");

        // Drain slot 7 then request once more.
        n_ok = 0;
        for (int i = 0; i < 5; i++) begin
            do_disp(4'd7, 10, -1, -1, 1'b0, ok, lat, mc, sel_bad);
            if (ok) n_ok++;
        end
        check_val("s7_drain_ok", 32'(n_ok), 32'd5);
        do_disp(4'd7, 10, -1, -1, 1'b0, ok, lat, mc, sel_bad);
        check_val("s7_empty_ok", 32'(ok), 32'd0);
        check_val("s7_empty_lat", 32'(lat), 32'd2);
        check_val("s7_empty_motor", 32'(mc), 32'd0);
        chk_avail(4'd7, 1'b0, "s7_avail");

        // Cancel with req fails in CHECK; cancel during motor is ignored.
        do_disp(4'd0, -1, 0, 1, 1'b0, ok, lat, mc, sel_bad);
        check_val("cancel_req_ok", 32'(ok), 32'd0);
        check_val("cancel_req_lat", 32'(lat), 32'd2);
        check_val("cancel_req_motor", 32'(mc), 32'd0);
        chk_avail(4'd0, 1'b1, "cancel_req_avail");
        do_disp(4'd0, 10, 3, 6, 1'b0, ok, lat, mc, sel_bad);
        check_val("cancel_motor_ok", 32'(ok), 32'd1);
        check_val("cancel_motor_lat", 32'(lat), 32'd11);
        check_val("cancel_motor_cycles", 32'(mc), 32'd8);

        // Restock slot 2 by 15 from 5: saturates at 15.
        restockEn = 1'b1; restockIndex = 4'd2; restockCount = 4'd15;
        tick();
        restockEn = 1'b0;
        n_ok = 0;
        for (int i = 0; i < 15; i++) begin
            do_disp(4'd2, 10, -1, -1, 1'b0, ok, lat, mc, sel_bad);
            if (ok) n_ok++;
        end
        check_val("s2_sat_ok", 32'(n_ok), 32'd15);
        do_disp(4'd2, 10, -1, -1, 1'b0, ok, lat, mc, sel_bad);
        check_val("s2_sat_empty", 32'(ok), 32'd0);

        // Restock empty slot 7 by 1 with req on the same cycle; drop during motor.
        do_disp(4'd7, 6, -1, -1, 1'b1, ok, lat, mc, sel_bad);
        check_val("rs_req_ok", 32'(ok), 32'd1);
        check_val("rs_req_lat", 32'(lat), 32'd12);
        check_val("rs_req_motor", 32'(mc), 32'd8);
        check_val("rs_req_sel", 32'(sel_bad), 32'd0);
        chk_avail(4'd7, 1'b0, "rs_req_avail");

        // Jam: no drop at all.
        do_disp(4'd4, -1, -1, -1, 1'b0, ok, lat, mc, sel_bad);
        check_val("jam_ok", 32'(ok), 32'd0);
        check_val("jam_lat", 32'(lat), 32'd50);
        check_val("jam_motor", 32'(mc), 32'd8);
        check_val("jam_flag", 32'(jamFault), 32'd1);
        chk_avail(4'd4, 1'b0, "jam_avail");
        do_disp(4'd4, 10, -1, -1, 1'b0, ok, lat, mc, sel_bad);
        check_val("jam_req_ok", 32'(ok), 32'd0);
        check_val("jam_req_lat", 32'(lat), 32'd2);
        faultClear = 1'b1;
        tick();
        faultClear = 1'b0;
        check_val("jam_cleared", 32'(jamFault), 32'd0);
        chk_avail(4'd4, 1'b1, "jam_clear_avail");

        // Reset during MOTOR.
        dispenseReq = 1'b1; dispenseIndex = 4'd5;
        repeat (4) tick();
        check_val("prerst_motor", 32'(motorEn), 32'd1);
        rst = 1'b1;
        tick();
        check_val("midrst_motor", 32'(motorEn), 32'd0);
        check_val("midrst_done", 32'(dispenseDone), 32'd0);
        rst = 1'b0; dispenseReq = 1'b0;
        tick();
        avail_mask = '0;
        for (int i = 0; i < 16; i++) begin
            queryIndex = 4'(i);
            #1;
            avail_mask[i] = stockAvail;
        end
        check_val("midrst_avail_all", 32'(avail_mask), 32'h0000_FFFF);
        check_val("midrst_motor_idle", 32'(motorEn), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
